// File: rtl/processador_param.sv
// Parametrised multicycle processor: DATA_W-bit datapath, 2**REG_AW registers (last one is the PC),
// memory wait-state handshake, zero flag, mvnz and AND, plus a combinational debug read port.
module processador_param #(
    parameter  int DATA_W = 16,
    parameter  int REG_AW = 3,
    localparam int IR_W   = 3 + 2*REG_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    input  logic              mem_ready,
    output logic              done,
    output logic              w,
    output logic [DATA_W-1:0] daddr,
    output logic [DATA_W-1:0] dout,
    output logic [IR_W-1:0]   ir,
    output logic [DATA_W-1:0] pc,
    output logic              zflag,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    // state | meaning
    // F0    | drive PC onto daddr, increment PC
    // F1    | wait for instruction word, latch ir
    // T1    | decode: mv/mvnz finish, others set up operand or address
    // T2    | mvi/ld data wait, ALU compute, st launch write
    // T3    | ALU writeback, st wait for write completion
    typedef enum logic [2:0] {S_F0, S_F1, S_T1, S_T2, S_T3} state_t;

    localparam int NREGS = 2**REG_AW;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_MVNZ = 3'd6;
    localparam logic [2:0] OP_AND  = 3'd7;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_g;
    state_t            r_state;

    logic [2:0]        w_op;
    logic [REG_AW-1:0] w_rx;
    logic [REG_AW-1:0] w_ry;
    logic [DATA_W-1:0] w_rx_val;
    logic [DATA_W-1:0] w_ry_val;
    logic [DATA_W-1:0] w_pc;
    logic [DATA_W-1:0] w_alu_res;

    assign w_op     = ir[IR_W-1 -: 3];
    assign w_rx     = ir[2*REG_AW-1 -: REG_AW];
    assign w_ry     = ir[REG_AW-1:0];
    assign w_rx_val = r_regs[w_rx];
    assign w_ry_val = r_regs[w_ry];
    assign w_pc     = r_regs[NREGS-1];
    assign pc       = w_pc;
    assign dbg_data = r_regs[dbg_sel];

    always_comb begin
        w_alu_res = r_a + w_ry_val;
        case (w_op)
            OP_SUB:  w_alu_res = r_a - w_ry_val;
            OP_AND:  w_alu_res = r_a & w_ry_val;
            default: w_alu_res = r_a + w_ry_val;
        endcase
    end

    // done marks the cycle whose closing edge retires the instruction
    always_comb begin
        done = 1'b0;
        if (run) begin
            case (r_state)
                S_T1:    done = (w_op == OP_MV) || (w_op == OP_MVNZ);
                S_T2:    done = ((w_op == OP_MVI) || (w_op == OP_LD)) && mem_ready;
                S_T3:    done = (w_op == OP_ST) ? mem_ready : 1'b1;
                default: done = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_a     <= '0;
            r_g     <= '0;
            daddr   <= '0;
            dout    <= '0;
            ir      <= '0;
            zflag   <= 1'b0;
            w       <= 1'b0;
            r_state <= S_F0;
        end else if (run) begin
            case (r_state)
                S_F0: begin
                    daddr             <= w_pc;
                    r_regs[NREGS-1]   <= w_pc + ONE;
                    r_state           <= S_F1;
                end
                S_F1: begin
                    if (mem_ready) begin
                        ir      <= din[DATA_W-1 -: IR_W];
                        r_state <= S_T1;
                    end
                end
                S_T1: begin
                    case (w_op)
                        OP_MV: begin
                            r_regs[w_rx] <= w_ry_val;
                            r_state      <= S_F0;
                        end
                        OP_MVNZ: begin
                            if (!zflag) r_regs[w_rx] <= w_ry_val;
                            r_state <= S_F0;
                        end
                        OP_MVI: begin
                            daddr           <= w_pc;
                            r_regs[NREGS-1] <= w_pc + ONE;
                            r_state         <= S_T2;
                        end
                        OP_LD, OP_ST: begin
                            daddr   <= w_ry_val;
                            r_state <= S_T2;
                        end
                        default: begin
                            r_a     <= w_rx_val;
                            r_state <= S_T2;
                        end
                    endcase
                end
                S_T2: begin
                    case (w_op)
                        OP_MVI, OP_LD: begin
                            if (mem_ready) begin
                                r_regs[w_rx] <= din;
                                r_state      <= S_F0;
                            end
                        end
                        OP_ST: begin
                            dout    <= w_rx_val;
                            w       <= 1'b1;
                            r_state <= S_T3;
                        end
                        default: begin
                            r_g     <= w_alu_res;
                            zflag   <= (w_alu_res == '0);
                            r_state <= S_T3;
                        end
                    endcase
                end
                S_T3: begin
                    if (w_op == OP_ST) begin
                        if (mem_ready) begin
                            w       <= 1'b0;
                            r_state <= S_F0;
                        end
                    end else begin
                        r_regs[w_rx] <= r_g;
                        r_state      <= S_F0;
                    end
                end
                default: r_state <= S_F0;
            endcase
        end
    end

endmodule

// File: tb/tb_processador_param.sv
// Directed bench for processador_param: 16-bit/8-register core running a fixed program,
// plus an 8-bit/4-register instance repeating the mvi and wrapping-add scenarios.
module tb_processador_param;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // 16-bit, 8-register instance
    logic        rst, run, ready;
    logic [15:0] din16, daddr16, dout16, pc16, dbg16;
    logic        done16, w16, z16;
    logic [8:0]  ir16;
    logic [2:0]  sel16;
    logic [15:0] mem16 [256];

    assign din16 = mem16[daddr16[7:0]];

    processador_param #(.DATA_W(16), .REG_AW(3)) dut16 (
        .clock(clock), .reset(rst), .run(run), .din(din16), .mem_ready(ready),
        .done(done16), .w(w16), .daddr(daddr16), .dout(dout16), .ir(ir16),
        .pc(pc16), .zflag(z16), .dbg_sel(sel16), .dbg_data(dbg16)
    );

    int          wr_count = 0;
    logic [15:0] wr_addr  = '0;
    logic [15:0] wr_data  = '0;
    always @(posedge clock) begin
        if (!rst && run && w16 && ready) begin
            wr_count <= wr_count + 1;
            wr_addr  <= daddr16;
            wr_data  <= dout16;
        end
    end

    // 8-bit, 4-register instance
    logic        rst8, run8, ready8;
    logic [7:0]  din8, daddr8, dout8, pc8, dbg8;
    logic        done8, w8, z8;
    logic [6:0]  ir8;
    logic [1:0]  sel8;
    logic [7:0]  mem8 [256];

    assign din8 = mem8[daddr8];

    processador_param #(.DATA_W(8), .REG_AW(2)) dut8 (
        .clock(clock), .reset(rst8), .run(run8), .din(din8), .mem_ready(ready8),
        .done(done8), .w(w8), .daddr(daddr8), .dout(dout8), .ir(ir8),
        .pc(pc8), .zflag(z8), .dbg_sel(sel8), .dbg_data(dbg8)
    );

    function automatic logic [15:0] enc16(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {op, rx, ry, 7'b0};
    endfunction

    function automatic logic [7:0] enc8(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry);
        return {op, rx, ry, 1'b0};
    endfunction

    int c_mvi, c_alu, c_mv, c_tmp;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic rd16(input logic [2:0] s, output logic [15:0] v);
        sel16 = s;
        #1;
        v = dbg16;
    endtask

    task automatic rd8(input logic [1:0] s, output logic [7:0] v);
        sel8 = s;
        #1;
        v = dbg8;
    endtask

    // Cycles from call until done is seen, then steps across the retiring edge
    task automatic wait_done16(output int cyc);
        cyc = 0;
        while (!done16 && cyc < 60) begin
            tick;
            cyc++;
        end
        checks++;
        if (!done16) begin
            errors++;
            $display("FAIL done16_timeout: done=%0b after %0d cycles, required 1", done16, cyc);
        end
        tick;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (!done8 && cyc < 60) begin
            tick;
            cyc++;
        end
        checks++;
        if (!done8) begin
            errors++;
            $display("FAIL done8_timeout: done=%0b after %0d cycles, required 1", done8, cyc);
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b1; ready = 1'b1; sel16 = '0;
        tick; tick;
        checks++; if (pc16 !== 16'd0)    begin errors++; $display("FAIL reset_pc: got %h, required 0000", pc16); end
        checks++; if (w16 !== 1'b0)      begin errors++; $display("FAIL reset_w: got %b, required 0", w16); end
        checks++; if (daddr16 !== 16'd0) begin errors++; $display("FAIL reset_daddr: got %h, required 0000", daddr16); end
        checks++; if (ir16 !== 9'd0)     begin errors++; $display("FAIL reset_ir: got %h, required 000", ir16); end
        checks++; if (done16 !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b, required 0", done16); end
        checks++; if (dbg16 !== 16'd0)   begin errors++; $display("FAIL reset_r0: got %h, required 0000", dbg16); end
        rst = 1'b0;
    endtask

    task automatic test_mvi;
        logic [15:0] v;
        wait_done16(c_mvi);
        rd16(3'd0, v);
        checks++; if (v !== 16'd5)    begin errors++; $display("FAIL mvi_r0: got %h, required 0005", v); end
        checks++; if (pc16 !== 16'd2) begin errors++; $display("FAIL mvi_pc: got %h, required 0002", pc16); end
    endtask

    task automatic test_sub_mvnz;
        logic [15:0] v;
        wait_done16(c_tmp);
        wait_done16(c_tmp);
        wait_done16(c_alu);
        rd16(3'd0, v);
        checks++; if (v !== 16'd0)  begin errors++; $display("FAIL sub_r0: got %h, required 0000", v); end
        checks++; if (z16 !== 1'b1) begin errors++; $display("FAIL sub_zflag: got %b, required 1", z16); end
        wait_done16(c_mv);
        rd16(3'd2, v);
        checks++; if (v !== 16'd0)  begin errors++; $display("FAIL mvnz_r2_held: got %h, required 0000", v); end
        checks++; if (c_mvi - c_mv !== 1)  begin errors++; $display("FAIL len_mvi_vs_mv: got %0d, required 1", c_mvi - c_mv); end
        checks++; if (c_alu - c_mvi !== 1) begin errors++; $display("FAIL len_alu_vs_mvi: got %0d, required 1", c_alu - c_mvi); end
    endtask

    task automatic test_add_wrap;
        logic [15:0] v;
        wait_done16(c_tmp);
        wait_done16(c_tmp);
        wait_done16(c_tmp);
        rd16(3'd0, v);
        checks++; if (v !== 16'd1)  begin errors++; $display("FAIL add_wrap_r0: got %h, required 0001", v); end
        checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL add_zflag: got %b, required 0", z16); end
        wait_done16(c_tmp);
        rd16(3'd2, v);
        checks++; if (v !== 16'd2)  begin errors++; $display("FAIL mvnz_r2_moved: got %h, required 0002", v); end
    endtask

    task automatic test_store_wait;
        logic [15:0] v;
        int n, wcnt;
        wait_done16(c_tmp);
        wait_done16(c_tmp);
        n = 0;
        while (!w16 && n < 20) begin tick; n++; end
        ready = 1'b0;
        checks++; if (dout16 !== 16'hABCD) begin errors++; $display("FAIL st_dout: got %h, required abcd", dout16); end
        wcnt = w16 ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (w16) wcnt++;
            checks++; if (daddr16 !== 16'h0040) begin errors++; $display("FAIL st_daddr_stable: got %h, required 0040", daddr16); end
            checks++; if (done16 !== 1'b0)      begin errors++; $display("FAIL st_done_early: got %b, required 0", done16); end
        end
        ready = 1'b1;
        #1;
        checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL st_done_on_ready: got %b, required 1", done16); end
        tick;
        checks++; if (wcnt !== 4)      begin errors++; $display("FAIL st_w_cycles: got %0d, required 4", wcnt); end
        checks++; if (w16 !== 1'b0)    begin errors++; $display("FAIL st_w_drop: got %b, required 0", w16); end
        checks++; if (wr_count !== 1 || wr_addr !== 16'h0040 || wr_data !== 16'hABCD)
            begin errors++; $display("FAIL st_mem_write: got n=%0d a=%h d=%h, required n=1 a=0040 d=abcd", wr_count, wr_addr, wr_data); end
        wait_done16(c_tmp);
        rd16(3'd6, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL ld_r6: got %h, required 1234", v); end
        wait_done16(c_tmp);
        rd16(3'd6, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL and_r6: got %h, required 0000", v); end
        checks++; if (z16 !== 1'b1)   begin errors++; $display("FAIL and_zflag: got %b, required 1", z16); end
    endtask

    task automatic test_jump;
        wait_done16(c_tmp);
        wait_done16(c_tmp);
        checks++; if (pc16 !== 16'h0020) begin errors++; $display("FAIL jump_pc: got %h, required 0020", pc16); end
        tick;
        checks++; if (daddr16 !== 16'h0020) begin errors++; $display("FAIL jump_fetch: got %h, required 0020", daddr16); end
    endtask

    task automatic test_run_freeze;
        logic [15:0] v;
        tick; tick; tick;
        checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL frz_t3_done: got %b, required 1", done16); end
        run = 1'b0;
        #1;
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL frz_done_gated: got %b, required 0", done16); end
        for (int i = 0; i < 3; i++) begin
            tick;
            rd16(3'd1, v);
            checks++; if (v !== 16'd2 || pc16 !== 16'h0021 || done16 !== 1'b0)
                begin errors++; $display("FAIL frz_hold: got r1=%h pc=%h done=%b, required 0002 0021 0", v, pc16, done16); end
        end
        run = 1'b1;
        #1;
        checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL frz_resume_done: got %b, required 1", done16); end
        tick;
        rd16(3'd1, v);
        checks++; if (v !== 16'd4)  begin errors++; $display("FAIL frz_add_r1: got %h, required 0004", v); end
        checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL frz_zflag: got %b, required 0", z16); end
    endtask

    task automatic test_reset_mid_store;
        int n;
        n = 0;
        while (!w16 && n < 20) begin tick; n++; end
        ready = 1'b0;
        tick;
        checks++; if (w16 !== 1'b1) begin errors++; $display("FAIL rst_st_w_pre: got %b, required 1", w16); end
        rst = 1'b1;
        tick;
        checks++; if (w16 !== 1'b0)   begin errors++; $display("FAIL rst_st_w: got %b, required 0", w16); end
        checks++; if (pc16 !== 16'd0) begin errors++; $display("FAIL rst_st_pc: got %h, required 0000", pc16); end
        rst = 1'b0;
        ready = 1'b1;
        tick;
        checks++; if (daddr16 !== 16'd0 || pc16 !== 16'd1)
            begin errors++; $display("FAIL rst_refetch: got daddr=%h pc=%h, required 0000 0001", daddr16, pc16); end
        tick;
        checks++; if (ir16 !== 9'h040) begin errors++; $display("FAIL rst_refetch_ir: got %h, required 040", ir16); end
        checks++; if (wr_count !== 1)  begin errors++; $display("FAIL rst_no_write: got %0d writes, required 1", wr_count); end
    endtask

    task automatic test_param8;
        logic [7:0] v;
        rst8 = 1'b1;
        tick;
        checks++; if (pc8 !== 8'd0 || w8 !== 1'b0) begin errors++; $display("FAIL p8_reset: got pc=%h w=%b, required 00 0", pc8, w8); end
        rst8 = 1'b0;
        wait_done8(c_tmp);
        rd8(2'd0, v);
        checks++; if (v !== 8'd5 || pc8 !== 8'd2) begin errors++; $display("FAIL p8_mvi: got r0=%h pc=%h, required 05 02", v, pc8); end
        wait_done8(c_tmp);
        wait_done8(c_tmp);
        wait_done8(c_tmp);
        rd8(2'd0, v);
        checks++; if (v !== 8'd1)  begin errors++; $display("FAIL p8_add_wrap: got %h, required 01", v); end
        checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL p8_zflag: got %b, required 0", z8); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem16[i] = '0; mem8[i] = '0; end
        mem16[0]  = enc16(3'd1, 3'd0, 3'd0); mem16[1]  = 16'd5;
        mem16[2]  = enc16(3'd1, 3'd0, 3'd0); mem16[3]  = 16'd3;
        mem16[4]  = enc16(3'd1, 3'd1, 3'd0); mem16[5]  = 16'd3;
        mem16[6]  = enc16(3'd3, 3'd0, 3'd1);
        mem16[7]  = enc16(3'd6, 3'd2, 3'd1);
        mem16[8]  = enc16(3'd1, 3'd0, 3'd0); mem16[9]  = 16'hFFFF;
        mem16[10] = enc16(3'd1, 3'd1, 3'd0); mem16[11] = 16'd2;
        mem16[12] = enc16(3'd2, 3'd0, 3'd1);
        mem16[13] = enc16(3'd6, 3'd2, 3'd1);
        mem16[14] = enc16(3'd1, 3'd3, 3'd0); mem16[15] = 16'hABCD;
        mem16[16] = enc16(3'd1, 3'd4, 3'd0); mem16[17] = 16'h0040;
        mem16[18] = enc16(3'd5, 3'd3, 3'd4);
        mem16[19] = enc16(3'd4, 3'd6, 3'd4);
        mem16[20] = enc16(3'd7, 3'd6, 3'd1);
        mem16[21] = enc16(3'd1, 3'd5, 3'd0); mem16[22] = 16'h0020;
        mem16[23] = enc16(3'd0, 3'd7, 3'd5);
        mem16[32] = enc16(3'd2, 3'd1, 3'd1);
        mem16[33] = enc16(3'd5, 3'd3, 3'd4);
        mem16[64] = 16'h1234;

        mem8[0] = enc8(3'd1, 2'd0, 2'd0); mem8[1] = 8'd5;
        mem8[2] = enc8(3'd1, 2'd0, 2'd0); mem8[3] = 8'hFF;
        mem8[4] = enc8(3'd1, 2'd1, 2'd0); mem8[5] = 8'd2;
        mem8[6] = enc8(3'd2, 2'd0, 2'd1);

        rst8 = 1'b1; run8 = 1'b1; ready8 = 1'b1; sel8 = '0;

        test_reset;
        test_mvi;
        test_sub_mvnz;
        test_add_wrap;
        test_store_wait;
        test_jump;
        test_run_freeze;
        test_reset_mid_store;
        test_param8;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
